// File: rtl/tri_mon.sv
// Receive-side monitor for a W-bit up/down triangle stream with two-sample dwell at each end.
// Locks onto the sequence, tracks direction, flags violations and counts periods and errors.
module tri_mon #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          en,
    input  logic [W-1:0]  x,
    output logic          lock,
    output logic          dir,
    output logic          err,
    output logic          peak,
    output logic          trough,
    output logic [CW-1:0] per_cnt,
    output logic [CW-1:0] err_cnt
);
    localparam logic [W-1:0] MAX = '1;

    typedef enum logic [2:0] {HUNT, UP, TOP, DOWN, BOT} st_t;

    st_t           st_q, st_d;
    logic          hv_q, hv_d;
    logic [W-1:0]  prev_q, prev_d;
    logic          lock_q, lock_d, dir_q, dir_d;
    logic          err_q, err_d, peak_q, peak_d, trough_q, trough_d;
    logic [CW-1:0] per_q, per_d, errc_q, errc_d;

    logic step_up, step_dn, is_max, is_zero, viol;

    // One bit of headroom so MAX->0 and 0->MAX can never look like steps
    assign step_up = ({1'b0, prev_q} + (W+1)'(1)) == {1'b0, x};
    assign step_dn = (prev_q != '0) && (({1'b0, prev_q} - (W+1)'(1)) == {1'b0, x});
    assign is_max  = (x == MAX);
    assign is_zero = (x == '0);

    always_comb begin
        st_d     = st_q;
        hv_d     = hv_q;
        prev_d   = prev_q;
        dir_d    = dir_q;
        err_d    = 1'b0;
        peak_d   = 1'b0;
        trough_d = 1'b0;
        per_d    = per_q;
        errc_d   = errc_q;
        viol     = 1'b0;
        if (en) begin
            prev_d = x;
            case (st_q)
                HUNT: begin
                    if (!hv_q)                          hv_d = 1'b1;
                    else if (step_up)                   st_d = is_max  ? TOP : UP;
                    else if (step_dn)                   st_d = is_zero ? BOT : DOWN;
                    else if (is_zero && prev_q == '0)   st_d = UP;
                    else if (is_max  && prev_q == MAX)  st_d = DOWN;
                end
                UP: begin
                    if (step_up) st_d = is_max ? TOP : UP;
                    else         viol = 1'b1;
                end
                TOP: begin
                    if (is_max) begin
                        st_d   = DOWN;
                        peak_d = 1'b1;
                    end else viol = 1'b1;
                end
                DOWN: begin
                    if (step_dn) st_d = is_zero ? BOT : DOWN;
                    else         viol = 1'b1;
                end
                BOT: begin
                    if (is_zero) begin
                        st_d     = UP;
                        trough_d = 1'b1;
                        per_d    = per_q + CW'(1);
                    end else viol = 1'b1;
                end
                default: st_d = HUNT;
            endcase
            if (viol) begin
                err_d = 1'b1;
                st_d  = HUNT;
                hv_d  = 1'b1;
                if (errc_q != '1) errc_d = errc_q + CW'(1);
            end
        end
        // Direction is sticky while hunting
        case (st_d)
            UP, TOP:   dir_d = 1'b1;
            DOWN, BOT: dir_d = 1'b0;
            default:   dir_d = dir_q;
        endcase
        lock_d = (st_d != HUNT);
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            st_q     <= HUNT;
            hv_q     <= 1'b0;
            prev_q   <= '0;
            lock_q   <= 1'b0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
            peak_q   <= 1'b0;
            trough_q <= 1'b0;
            per_q    <= '0;
            errc_q   <= '0;
        end else begin
            st_q     <= st_d;
            hv_q     <= hv_d;
            prev_q   <= prev_d;
            lock_q   <= lock_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            peak_q   <= peak_d;
            trough_q <= trough_d;
            per_q    <= per_d;
            errc_q   <= errc_d;
        end
    end

    assign lock    = lock_q;
    assign dir     = dir_q;
    assign err     = err_q;
    assign peak    = peak_q;
    assign trough  = trough_q;
    assign per_cnt = per_q;
    assign err_cnt = errc_q;
endmodule

// File: tb/tb_tri_mon.sv
// Directed bench for tri_mon: phase-tracking reference model checked every cycle,
// plus literal checkpoints that pin the model.
module tb_tri_mon;
    localparam int W  = 4;
    localparam int CW = 8;

    logic          ck = 1'b0;
    logic          rst, en;
    logic [W-1:0]  x;
    logic          lock, dir, err, peak, trough;
    logic [CW-1:0] per_cnt, err_cnt;

    int ncmp = 0;
    int nbad = 0;

    tri_mon #(.W(W), .CW(CW)) dut (
        .ck(ck), .rst(rst), .en(en), .x(x),
        .lock(lock), .dir(dir), .err(err), .peak(peak), .trough(trough),
        .per_cnt(per_cnt), .err_cnt(err_cnt)
    );

    always #5 ck = ~ck;

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Value at position p of the 32-sample period 0,0,1..15,15,14..1
    function automatic int seqv(input int p);
        if (p <= 1)  return 0;
        if (p <= 16) return p - 1;
        if (p == 17) return 15;
        return 32 - p;
    endfunction

    // Reference model: once locked, the monitor knows its phase in the period
    // and demands exactly the next sample of the ideal sequence.
    bit m_lock, m_dir, m_hv, m_err, m_peak, m_tr;
    int m_p, m_prev, m_per, m_errc;

    initial begin
        forever begin
            @(posedge ck);
            if (!rst) begin
                m_lock = 0; m_dir = 0; m_hv = 0; m_prev = 0; m_p = 0;
                m_per = 0; m_errc = 0; m_err = 0; m_peak = 0; m_tr = 0;
            end else begin
                m_err = 0; m_peak = 0; m_tr = 0;
                if (en) begin
                    int xi, np;
                    xi = int'(x);
                    if (!m_lock) begin
                        if (!m_hv) m_hv = 1;
                        else if (xi == m_prev + 1) begin
                            m_lock = 1; m_p = (xi == 15) ? 16 : xi + 1;
                        end else if (xi == m_prev - 1) begin
                            m_lock = 1; m_p = (xi == 0) ? 0 : 32 - xi;
                        end else if (xi == 0 && m_prev == 0) begin
                            m_lock = 1; m_p = 1;
                        end else if (xi == 15 && m_prev == 15) begin
                            m_lock = 1; m_p = 17;
                        end
                    end else begin
                        np = (m_p + 1) % 32;
                        if (xi == seqv(np)) begin
                            m_p = np;
                            if (np == 17) m_peak = 1;
                            if (np == 1) begin
                                m_tr = 1;
                                m_per = (m_per + 1) % 256;
                            end
                        end else begin
                            m_err = 1; m_lock = 0; m_hv = 1;
                            if (m_errc < 255) m_errc++;
                        end
                    end
                    if (m_lock) m_dir = (m_p >= 1 && m_p <= 16);
                    m_prev = xi;
                end
            end
            #1;
            chk("m_lock",   int'(lock),    int'(m_lock));
            chk("m_dir",    int'(dir),     int'(m_dir));
            chk("m_err",    int'(err),     int'(m_err));
            chk("m_peak",   int'(peak),    int'(m_peak));
            chk("m_trough", int'(trough),  int'(m_tr));
            chk("m_per",    int'(per_cnt), m_per);
            chk("m_errcnt", int'(err_cnt), m_errc);
        end
    end

    task automatic send(input int v, input bit e);
        @(negedge ck);
        en = e;
        x  = W'(v);
        @(posedge ck);
        #2;
    endtask

    task automatic do_reset();
        @(negedge ck);
        rst = 1'b0;
        en  = 1'b0;
        @(negedge ck);
        rst = 1'b1;
    endtask

    initial begin
        int npk, ntr;
        rst = 1'b0; en = 1'b0; x = '0;
        repeat (2) @(negedge ck);
        chk("rst_outs", int'({lock, dir, err, peak, trough}), 0);
        chk("rst_cnts", int'({per_cnt, err_cnt}), 0);
        rst = 1'b1;

        // Clean stream s0..s33
        for (int i = 0; i < 34; i++) begin
            send(seqv(i % 32), 1'b1);
            if (i == 0)  chk("clean_s0_lock", int'(lock), 0);
            if (i == 1)  begin chk("clean_s1_lock", int'(lock), 1); chk("clean_s1_trough", int'(trough), 0); end
            if (i == 17) chk("clean_s17_peak", int'(peak), 1);
            if (i == 18) chk("clean_s18_dir", int'(dir), 0);
            if (i == 33) begin chk("clean_s33_trough", int'(trough), 1); chk("clean_s33_per", int'(per_cnt), 1); end
        end

        // Skip in UP
        for (int v = 1; v <= 5; v++) send(v, 1'b1);
        send(7, 1'b1);
        chk("skip_err", int'(err), 1);
        chk("skip_lock", int'(lock), 0);
        chk("skip_errcnt", int'(err_cnt), 1);
        send(8, 1'b1);
        chk("skip_relock", int'(lock), 1);
        chk("skip_dir", int'(dir), 1);
        chk("skip_noerr", int'(err), 0);

        // Single MAX at the top
        for (int v = 9; v <= 15; v++) send(v, 1'b1);
        send(14, 1'b1);
        chk("dwell_err", int'(err), 1);
        chk("dwell_nopeak", int'(peak), 0);
        chk("dwell_errcnt", int'(err_cnt), 2);
        send(13, 1'b1);
        chk("dwell_relock", int'(lock), 1);
        chk("dwell_dir", int'(dir), 0);

        // MAX<->0 jumps are never steps
        do_reset();
        send(15, 1'b1); send(0, 1'b1); send(15, 1'b1); send(0, 1'b1);
        chk("wrap_lock", int'(lock), 0);
        chk("wrap_errcnt", int'(err_cnt), 0);
        send(1, 1'b1);
        chk("wrap_relock", int'(lock), 1);
        chk("wrap_dir", int'(dir), 1);

        // Clean stream with idle cycles carrying garbage
        do_reset();
        npk = 0; ntr = 0;
        for (int i = 0; i < 34; i++) begin
            send(int'($urandom_range(0, 15)), 1'b0);
            send(seqv(i % 32), 1'b1);
            npk += int'(peak);
            ntr += int'(trough);
        end
        chk("gap_peaks", npk, 1);
        chk("gap_troughs", ntr, 1);
        chk("gap_per", int'(per_cnt), 1);
        chk("gap_errcnt", int'(err_cnt), 0);

        // Async reset in the middle of DOWN
        do_reset();
        for (int i = 0; i < 21; i++) send(seqv(i), 1'b1);
        chk("async_pre_lock", int'(lock), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_outs", int'({lock, dir, err, peak, trough}), 0);
        chk("async_cnts", int'({per_cnt, err_cnt}), 0);
        @(negedge ck);
        rst = 1'b1;
        send(3, 1'b1);
        chk("async_prime", int'(lock), 0);
        send(4, 1'b1);
        chk("async_relock", int'(lock), 1);

        // Saturate the error counter
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send(4, 1'b1); send(5, 1'b1); send(9, 1'b1);
        end
        chk("sat_err", int'(err), 1);
        chk("sat_errcnt", int'(err_cnt), 255);

        send(0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
